hub75_pixel_shifter: RTL and testbench

- Data-side responder to the HUB75 line controller. It answers the controller's latch_pts / sr_enable / shift_reg_empty handshake.
- On each line load it fetches one row pair from a double-buffered frame RAM and extracts the active BCM bit-plane.
- It presents one column of top-half and bottom-half RGB bits per sr_enable cycle, aligned to the controller's clk_out, and signals shift_reg_empty on the last column.
- It also owns front/back frame-buffer swapping, synchronised to the frame boundary.

---
 rtl/hub75_pkg.sv | 28 ++
 rtl/hub75_pixel_shifter_plane_select.sv | 35 +++
 rtl/hub75_pixel_shifter.sv | 146 ++++++++++++++
 tb/tb_hub75_pixel_shifter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 pixel shifter: FSM states, RAM word
// field slots and frame RAM address packing.
package hub75_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // RAM word field slots; a field's LSB sits at slot*DATA_WIDTH (top_r in the LSBs)
  localparam int unsigned TOP_R = 0;
  localparam int unsigned TOP_G = 1;
  localparam int unsigned TOP_B = 2;
  localparam int unsigned BOT_R = 3;
  localparam int unsigned BOT_G = 4;
  localparam int unsigned BOT_B = 5;
  localparam int unsigned NUM_FIELDS = 6;

  // {buf, row, col} frame RAM address, returned right-aligned in 32 bits
  function automatic int unsigned pack_addr(input logic        buf_sel,
                                            input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned row_bits,
                                            input int unsigned col_bits);
    return (32'(buf_sel) << (row_bits + col_bits)) | (row << col_bits) | col;
  endfunction

endpackage

// File: rtl/hub75_pixel_shifter_plane_select.sv
// Extracts one BCM bit-plane column (top and bottom {B,G,R}) from a frame RAM
// word; planes outside the channel width read as black.
module hub75_pixel_shifter_plane_select
  import hub75_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] word_i,
  input  logic [DATA_WIDTH-1:0]            bit_i,
  output logic [2:0]                       rgb_top_c_o,
  output logic [2:0]                       rgb_bot_c_o
);

  logic in_range;

  function automatic logic pick(input logic [NUM_FIELDS*DATA_WIDTH-1:0] w,
                                input int unsigned                      slot,
                                input logic [DATA_WIDTH-1:0]            b);
    return 1'((w >> (slot * DATA_WIDTH)) >> b);
  endfunction

  assign in_range = (32'(bit_i) < DATA_WIDTH);

  always_comb begin
    rgb_top_c_o = 3'b000;
    rgb_bot_c_o = 3'b000;
    if (in_range) begin
      rgb_top_c_o = {pick(word_i, TOP_B, bit_i), pick(word_i, TOP_G, bit_i),
                     pick(word_i, TOP_R, bit_i)};
      rgb_bot_c_o = {pick(word_i, BOT_B, bit_i), pick(word_i, BOT_G, bit_i),
                     pick(word_i, BOT_R, bit_i)};
    end
  end

endmodule

// File: rtl/hub75_pixel_shifter.sv
// HUB75 data-side responder: fetches a row pair per line load, presents one
// bit-plane column per sr_enable cycle and owns front/back buffer swapping.
module hub75_pixel_shifter
  import hub75_pkg::*;
#(
  parameter int unsigned MATRIX_WIDTH    = 64,
  parameter int unsigned MATRIX_HEIGHT   = 32,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned SCAN_VAL_LENGTH = 5,
  parameter int unsigned ROW_BITS        = 4,
  parameter int unsigned COL_BITS        = 6,
  parameter int unsigned ADDR_WIDTH      = 1 + ROW_BITS + COL_BITS
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [SCAN_VAL_LENGTH-1:0]       scan_val_i,
  input  logic [DATA_WIDTH-1:0]            current_bcm_bit_i,
  input  logic                             latch_pts_i,
  input  logic                             sr_enable_i,
  output logic                             shift_reg_empty_o,
  output logic [2:0]                       rgb_top_o,
  output logic [2:0]                       rgb_bot_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                             swap_req_i,
  output logic                             swap_ack_o,
  output logic                             sync_err_o
);

  localparam int unsigned LAST_COL = MATRIX_WIDTH - 1;
  localparam int unsigned COL_W1   = COL_BITS + 1;

  state_e                state_q;
  logic [COL_BITS-1:0]   col_q;
  logic                  buf_sel_q;
  logic [ROW_BITS-1:0]   row_q;
  logic [DATA_WIDTH-1:0] bit_q;
  logic                  swap_ack_q;
  logic                  sync_err_q;

  logic [ROW_BITS-1:0]   scan_row;
  logic                  col_last;
  logic                  swap_now;
  logic [COL_BITS:0]     col_inc_d;
  logic [COL_BITS-1:0]   col_adv;
  logic                  addr_buf;
  logic [ROW_BITS-1:0]   addr_row;
  logic [COL_BITS-1:0]   addr_col;
  logic [2:0]            sel_top;
  logic [2:0]            sel_bot;

  assign scan_row = scan_val_i[ROW_BITS-1:0];

  generate
    if (SCAN_VAL_LENGTH > ROW_BITS) begin : g_scan_hi
      logic scan_hi_unused;
      assign scan_hi_unused = ^scan_val_i[SCAN_VAL_LENGTH-1:ROW_BITS];
    end
  endgenerate

  // A frame starts at row pair 0, plane 0; only then may the buffers flip.
  assign swap_now = (state_q == IDLE) && latch_pts_i && swap_req_i &&
                    (scan_row == '0) && (current_bcm_bit_i == '0);

  assign col_last  = (col_q == COL_BITS'(LAST_COL));
  assign col_inc_d = {1'b0, col_q} + COL_W1'(1);
  assign col_adv   = col_inc_d[COL_BITS] ? '0 : col_inc_d[COL_BITS-1:0];

  // Prefetch: the address leads col by one whenever the column will advance.
  always_comb begin
    addr_buf = buf_sel_q;
    addr_row = row_q;
    addr_col = col_q;
    if (state_q == IDLE) begin
      addr_buf = buf_sel_q ^ swap_now;
      addr_row = scan_row;
      addr_col = '0;
    end else if (latch_pts_i) begin
      addr_row = scan_row;
      addr_col = '0;
    end else if (sr_enable_i) begin
      addr_col = col_adv;
    end
  end

  assign mem_addr_o = ADDR_WIDTH'(pack_addr(addr_buf, 32'(addr_row), 32'(addr_col),
                                            ROW_BITS, COL_BITS));

  hub75_pixel_shifter_plane_select #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_plane_select (
    .word_i      (mem_rdata_i),
    .bit_i       (bit_q),
    .rgb_top_c_o (sel_top),
    .rgb_bot_c_o (sel_bot)
  );

  assign rgb_top_o         = (state_q == SHIFT) ? sel_top : 3'b000;
  assign rgb_bot_o         = (state_q == SHIFT) ? sel_bot : 3'b000;
  assign shift_reg_empty_o = (state_q == IDLE) || col_last;
  assign swap_ack_o        = swap_ack_q;
  assign sync_err_o        = sync_err_q;

  // Line FSM, column counter, buffer select and status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      buf_sel_q  <= 1'b0;
      row_q      <= '0;
      bit_q      <= '0;
      swap_ack_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      swap_ack_q <= swap_now;
      case (state_q)
        IDLE: begin
          if (latch_pts_i) begin
            row_q   <= scan_row;
            bit_q   <= current_bcm_bit_i;
            col_q   <= '0;
            state_q <= SHIFT;
            if (swap_now) buf_sel_q <= ~buf_sel_q;
          end
        end
        SHIFT: begin
          if (latch_pts_i) begin
            sync_err_q <= 1'b1;
            row_q      <= scan_row;
            bit_q      <= current_bcm_bit_i;
            col_q      <= '0;
          end else if (sr_enable_i) begin
            if (col_last) begin
              col_q   <= '0;
              state_q <= IDLE;
            end else begin
              col_q <= col_inc_d[COL_BITS-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_pixel_shifter.sv
// Self-checking bench for hub75_pixel_shifter: directed line/plane/stall/swap/
// abort/reset scenarios plus random traffic against a line-level reference.
module tb_hub75_pixel_shifter;

  localparam int W    = 64;
  localparam int ROWS = 16;
  localparam int DW   = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [4:0]  scan_val;
  logic [7:0]  current_bcm_bit;
  logic        latch_pts;
  logic        sr_enable;
  logic        shift_reg_empty;
  logic [2:0]  rgb_top;
  logic [2:0]  rgb_bot;
  logic [10:0] mem_addr;
  logic [47:0] mem_rdata;
  logic        swap_req;
  logic        swap_ack;
  logic        sync_err;

  logic [47:0] ram [0:2047];

  int n_checks = 0;
  int n_bad    = 0;

  // reference state: what the controller-facing line looks like
  bit m_busy;
  int m_row, m_bit, m_col, m_buf;
  bit m_err, m_ack;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= ram[mem_addr];

  hub75_pixel_shifter dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .scan_val_i        (scan_val),
    .current_bcm_bit_i (current_bcm_bit),
    .latch_pts_i       (latch_pts),
    .sr_enable_i       (sr_enable),
    .shift_reg_empty_o (shift_reg_empty),
    .rgb_top_o         (rgb_top),
    .rgb_bot_o         (rgb_bot),
    .mem_addr_o        (mem_addr),
    .mem_rdata_i       (mem_rdata),
    .swap_req_i        (swap_req),
    .swap_ack_o        (swap_ack),
    .sync_err_o        (sync_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int word_idx(input int b, input int row, input int col);
    return b * ROWS * W + row * W + col;
  endfunction

  function automatic logic [2:0] plane_bits(input logic [47:0] w, input int base, input int b);
    return {1'(w >> (base + 2 * DW + b)), 1'(w >> (base + DW + b)), 1'(w >> (base + b))};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_row = 0; m_bit = 0; m_col = 0; m_buf = 0; m_err = 0; m_ack = 0;
  endtask

  // One controller cycle: drive, compare combinational outputs mid-cycle, advance model.
  task automatic step(input bit latch, input int scan, input int bcm, input bit sr, input bit swp);
    bit          swap_now;
    logic [47:0] w;
    logic [2:0]  et, eb;
    int          ea, srow;
    @(posedge clk);
    #1;
    latch_pts       = latch;
    scan_val        = 5'(scan);
    current_bcm_bit = 8'(bcm);
    sr_enable       = sr;
    swap_req        = swp;
    @(negedge clk);
    srow     = scan % ROWS;
    swap_now = !m_busy && latch && swp && srow == 0 && bcm == 0;
    et = 3'b000;
    eb = 3'b000;
    if (m_busy && m_bit < DW) begin
      w  = ram[word_idx(m_buf, m_row, m_col)];
      et = plane_bits(w, 0, m_bit);
      eb = plane_bits(w, 3 * DW, m_bit);
    end
    if (!m_busy)    ea = word_idx(m_buf ^ int'(swap_now), srow, 0);
    else if (latch) ea = word_idx(m_buf, srow, 0);
    else            ea = word_idx(m_buf, m_row, sr ? (m_col + 1) % W : m_col);
    check_eq("empty",    64'(shift_reg_empty), 64'(!m_busy || m_col == W - 1));
    check_eq("rgb_top",  64'(rgb_top),  64'(et));
    check_eq("rgb_bot",  64'(rgb_bot),  64'(eb));
    check_eq("mem_addr", 64'(mem_addr), 64'(ea));
    check_eq("swap_ack", 64'(swap_ack), 64'(m_ack));
    check_eq("sync_err", 64'(sync_err), 64'(m_err));
    m_ack = swap_now;
    if (!m_busy) begin
      if (latch) begin
        m_busy = 1; m_row = srow; m_bit = bcm; m_col = 0;
        if (swap_now) m_buf ^= 1;
      end
    end else if (latch) begin
      m_err = 1; m_row = srow; m_bit = bcm; m_col = 0;
    end else if (sr) begin
      if (m_col == W - 1) begin m_busy = 0; m_col = 0; end
      else m_col++;
    end
  endtask

  task automatic run_line(input int scan, input int bcm, input bit swp);
    step(1, scan, bcm, 0, swp);
    for (int c = 0; c < W; c++) step(0, scan, bcm, 1, swp);
  endtask

  initial begin
    int empties;
    n_rst = 1'b0; latch_pts = 0; sr_enable = 0; swap_req = 0;
    scan_val = '0; current_bcm_bit = '0;
    for (int i = 0; i < 2048; i++) ram[i] = {$urandom, $urandom};
    model_reset();
    #12;
    check_eq("rst_empty", 64'(shift_reg_empty), 64'(1));
    check_eq("rst_rgb",   64'({rgb_top, rgb_bot}), 64'(0));
    check_eq("rst_ack",   64'(swap_ack), 64'(0));
    check_eq("rst_err",   64'(sync_err), 64'(0));
    @(negedge clk) n_rst = 1'b1;
    step(0, 0, 0, 0, 0);

    // full line: top_r = column index, alternating rgb_top[0]
    for (int c = 0; c < W; c++) ram[word_idx(0, 3, c)] = 48'(c);
    step(1, 3, 0, 0, 0);
    empties = 0;
    for (int c = 0; c < W; c++) begin
      step(0, 3, 0, 1, 0);
      if (shift_reg_empty) empties++;
    end
    check_eq("line_empties", 64'(empties), 64'(1));
    step(0, 3, 0, 0, 0);

    // bit-plane select: bot_g = A5 on every column, planes 0..8
    for (int c = 0; c < W; c++) ram[word_idx(0, 3, c)] = 48'hA5 << (4 * DW);
    for (int b = 0; b <= DW; b++) run_line(3, b, 0);

    // stall three cycles at column 10
    step(1, 6, 2, 0, 0);
    for (int c = 0; c < 10; c++) step(0, 6, 2, 1, 0);
    for (int s = 0; s < 3; s++)  step(0, 6, 2, 0, 0);
    for (int c = 10; c < W; c++) step(0, 6, 2, 1, 0);
    step(0, 6, 2, 0, 0);
    check_eq("stall_idle", 64'(shift_reg_empty), 64'(1));

    // swap: only at row 0 / plane 0 latches
    run_line(5, 0, 1);
    run_line(0, 0, 1);
    run_line(1, 0, 1);
    run_line(0, 3, 1);
    run_line(0, 0, 1);

    // abort at column 20 with row 7
    step(1, 2, 1, 0, 0);
    for (int c = 0; c < 20; c++) step(0, 2, 1, 1, 0);
    step(1, 7, 1, 1, 0);
    for (int c = 0; c < W; c++) step(0, 7, 1, 1, 0);
    run_line(4, 4, 0);

    // random traffic
    for (int i = 0; i < 2048; i++) ram[i] = {$urandom, $urandom};
    for (int i = 0; i < 4000; i++) begin
      bit lt;
      int sc, bc;
      lt = m_busy ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 2) == 0);
      sc = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
      bc = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 9));
      step(lt, sc, bc, $urandom_range(0, 4) != 0, 1'($urandom));
    end
    while (m_busy) step(0, 0, 0, 1, 0);

    // asynchronous reset mid-shift with the back buffer displayed
    if (m_buf == 0) run_line(0, 0, 1);
    step(1, 4, 0, 0, 0);
    for (int c = 0; c < 30; c++) step(0, 4, 0, 1, 0);
    @(posedge clk);
    #2;
    swap_req = 1'b0;
    n_rst    = 1'b0;
    #1;
    check_eq("arst_empty",   64'(shift_reg_empty), 64'(1));
    check_eq("arst_rgb",     64'({rgb_top, rgb_bot}), 64'(0));
    check_eq("arst_ack",     64'(swap_ack), 64'(0));
    check_eq("arst_buf_sel", 64'(mem_addr[10]), 64'(0));
    model_reset();
    @(negedge clk) n_rst = 1'b1;
    run_line(9, 1, 0);
    step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
